// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-field width and the pipeline controller state.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: the EX-stage load writes a register that the
// ID-stage instruction reads. Register 0 is hardwired and never a hazard.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dREN_i,
  input  regbits_t idex_rt_i,
  input  regbits_t ifid_rs_i,
  input  regbits_t ifid_rt_i,
  output logic     loaduse_o
);

  // Pure compare; no state.
  always_comb begin
    loaduse_o = idex_dREN_i && (idex_rt_i != '0) &&
                ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: drives latch
// enable/nop pairs and the PC write enable, sequences halt, and keeps
// saturating stall/flush counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_pcsrc,
  input  logic             exmem_halt,
  input  logic             idex_dREN,
  input  regbits_t         idex_rt,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  output logic             pc_en,
  output logic             ifid_enable,
  output logic             idex_enable,
  output logic             exmem_enable,
  output logic             memwb_enable,
  output logic             ifid_nop,
  output logic             idex_nop,
  output logic             exmem_nop,
  output logic             memwb_nop,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             loaduse;
  logic             memreq;
  logic             stall_evt;
  logic             flush_evt;

  hazard_detect u_hazard_detect (
    .idex_dREN_i (idex_dREN),
    .idex_rt_i   (idex_rt),
    .ifid_rs_i   (ifid_rs),
    .ifid_rt_i   (ifid_rt),
    .loaduse_o   (loaduse)
  );

  assign memreq = exmem_dREN | exmem_dWEN;

  // Next state and control outputs; RUN and MEMWAIT share one priority chain.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    pc_en        = 1'b1;
    ifid_enable  = 1'b1;
    idex_enable  = 1'b1;
    exmem_enable = 1'b1;
    memwb_enable = 1'b1;
    ifid_nop     = 1'b0;
    idex_nop     = 1'b0;
    exmem_nop    = 1'b0;
    memwb_nop    = 1'b0;
    halt         = 1'b0;
    stall_evt    = 1'b0;
    flush_evt    = 1'b0;

    if (RST) begin
      pc_en        = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwb_enable = 1'b0;
      ifid_nop     = 1'b1;
      idex_nop     = 1'b1;
      exmem_nop    = 1'b1;
      memwb_nop    = 1'b1;
      state_d      = RUN;
    end else begin
      unique case (state_q)
        RUN, MEMWAIT: begin
          state_d = RUN;
          if (memreq && !dhit) begin
            // Data-memory wait freezes everything upstream of MEM.
            pc_en        = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_nop    = 1'b1;
            state_d      = MEMWAIT;
          end else if (exmem_halt) begin
            pc_en     = 1'b0;
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
            exmem_nop = 1'b1;
            state_d   = DRAIN;
          end else if (exmem_pcsrc) begin
            ifid_nop  = 1'b1;
            idex_nop  = 1'b1;
            exmem_nop = 1'b1;
            flush_evt = 1'b1;
          end else if (loaduse) begin
            pc_en       = 1'b0;
            ifid_enable = 1'b0;
            idex_nop    = 1'b1;
          end else if (!ihit) begin
            pc_en    = 1'b0;
            ifid_nop = 1'b1;
          end
          stall_evt = !pc_en;
        end
        DRAIN: begin
          pc_en     = 1'b0;
          ifid_nop  = 1'b1;
          idex_nop  = 1'b1;
          exmem_nop = 1'b1;
          memwb_nop = 1'b1;
          state_d   = HALTED;
        end
        HALTED: begin
          pc_en        = 1'b0;
          ifid_enable  = 1'b0;
          idex_enable  = 1'b0;
          exmem_enable = 1'b0;
          memwb_enable = 1'b0;
          halt         = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating performance counters: hold at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed test-plan steps followed by
// random stimulus, compared against a phase-level reference model.
module tb_pipeline_ctrl;

  logic       CLK;
  logic       RST;
  logic       ihit, dhit;
  logic       exmem_dREN, exmem_dWEN, exmem_pcsrc, exmem_halt;
  logic       idex_dREN;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic        pc_en, ifid_enable, idex_enable, exmem_enable, memwb_enable;
  logic        ifid_nop, idex_nop, exmem_nop, memwb_nop, halt;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_en4, ifid_enable4, idex_enable4, exmem_enable4, memwb_enable4;
  logic        ifid_nop4, idex_nop4, exmem_nop4, memwb_nop4, halt4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = running (memory wait is just a repeated freeze),
  // 1 = draining, 2 = halted. Event counts are kept unbounded.
  int phase = 0;
  int n_stall = 0;
  int n_flush = 0;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .exmem_pcsrc(exmem_pcsrc), .exmem_halt(exmem_halt),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(pc_en), .ifid_enable(ifid_enable), .idex_enable(idex_enable),
    .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
    .ifid_nop(ifid_nop), .idex_nop(idex_nop), .exmem_nop(exmem_nop), .memwb_nop(memwb_nop),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .exmem_pcsrc(exmem_pcsrc), .exmem_halt(exmem_halt),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(pc_en4), .ifid_enable(ifid_enable4), .idex_enable(idex_enable4),
    .exmem_enable(exmem_enable4), .memwb_enable(memwb_enable4),
    .ifid_nop(ifid_nop4), .idex_nop(idex_nop4), .exmem_nop(exmem_nop4), .memwb_nop(memwb_nop4),
    .halt(halt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Control vector layout: {pc_en, enables IF/ID..MEM/WB, nops IF/ID..MEM/WB, halt}.
  function automatic logic [9:0] ctl(input logic pc, input logic [3:0] en,
                                     input logic [3:0] nop, input logic h);
    return {pc, en, nop, h};
  endfunction

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic quiet();
    ihit = 1'b1; dhit = 1'b0;
    exmem_dREN = 1'b0; exmem_dWEN = 1'b0; exmem_pcsrc = 1'b0; exmem_halt = 1'b0;
    idex_dREN = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
  endtask

  // Inputs are already applied; check mid-cycle, then advance model and clock.
  task automatic step(input string tag);
    logic [9:0] exp_v, obs_v, obs4_v;
    logic       lu, wait_mem;
    int         nxt;
    bit         is_flush;
    #4;
    nxt      = phase;
    is_flush = 1'b0;
    lu       = idex_dREN && idex_rt != 5'd0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    wait_mem = (exmem_dREN || exmem_dWEN) && !dhit;
    if (RST)             exp_v = ctl(1'b0, 4'b0000, 4'b1111, 1'b0);
    else if (phase == 2) exp_v = ctl(1'b0, 4'b0000, 4'b0000, 1'b1);
    else if (phase == 1) begin
      exp_v = ctl(1'b0, 4'b1111, 4'b1111, 1'b0);
      nxt   = 2;
    end else if (wait_mem)    exp_v = ctl(1'b0, 4'b0001, 4'b0001, 1'b0);
    else if (exmem_halt) begin
      exp_v = ctl(1'b0, 4'b1111, 4'b1110, 1'b0);
      nxt   = 1;
    end else if (exmem_pcsrc) begin
      exp_v    = ctl(1'b1, 4'b1111, 4'b1110, 1'b0);
      is_flush = 1'b1;
    end else if (lu)          exp_v = ctl(1'b0, 4'b0111, 4'b0100, 1'b0);
    else if (!ihit)           exp_v = ctl(1'b0, 4'b1111, 4'b1000, 1'b0);
    else                      exp_v = ctl(1'b1, 4'b1111, 4'b0000, 1'b0);

    obs_v  = {pc_en, ifid_enable, idex_enable, exmem_enable, memwb_enable,
              ifid_nop, idex_nop, exmem_nop, memwb_nop, halt};
    obs4_v = {pc_en4, ifid_enable4, idex_enable4, exmem_enable4, memwb_enable4,
              ifid_nop4, idex_nop4, exmem_nop4, memwb_nop4, halt4};

    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs_v, exp_v);
    end
    checks++;
    assert (obs4_v === exp_v) else begin
      errors++;
      $error("FAIL %s ctl4 observed=%b expected=%b", tag, obs4_v, exp_v);
    end
    checks++;
    assert (stall_cnt === 16'(sat(n_stall, 16))) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, sat(n_stall, 16));
    end
    checks++;
    assert (flush_cnt === 16'(sat(n_flush, 16))) else begin
      errors++;
      $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, sat(n_flush, 16));
    end
    checks++;
    assert (stall_cnt4 === 4'(sat(n_stall, 4))) else begin
      errors++;
      $error("FAIL %s stall_cnt4 observed=%0d expected=%0d", tag, stall_cnt4, sat(n_stall, 4));
    end
    checks++;
    assert (flush_cnt4 === 4'(sat(n_flush, 4))) else begin
      errors++;
      $error("FAIL %s flush_cnt4 observed=%0d expected=%0d", tag, flush_cnt4, sat(n_flush, 4));
    end

    @(posedge CLK);
    if (RST) begin
      phase = 0; n_stall = 0; n_flush = 0;
    end else begin
      if (phase == 0 && !exp_v[9]) n_stall++;
      if (is_flush) n_flush++;
      phase = nxt;
    end
    #1;
  endtask

  initial begin
    quiet();
    RST = 1'b1;
    step("reset0");
    step("reset1");
    RST = 1'b0;
    step("idle");

    // Load-use: one bubble, then the load has moved to MEM.
    idex_dREN = 1'b1; idex_rt = 5'd2; ifid_rs = 5'd2; ifid_rt = 5'd7;
    step("loaduse");
    quiet(); exmem_dREN = 1'b1; dhit = 1'b1;
    step("load_in_mem");
    quiet();

    // Register zero never creates a load-use hazard.
    idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    step("loaduse_r0");
    quiet();

    // Data wait for three cycles, then completion.
    exmem_dWEN = 1'b1;
    for (int i = 0; i < 3; i++) step("dwait");
    dhit = 1'b1;
    step("dwait_done");
    quiet();

    // dhit with no memory request is ignored.
    dhit = 1'b1;
    step("dhit_noreq");
    quiet();

    // Freeze outranks a simultaneous redirect and load-use.
    exmem_dREN = 1'b1; exmem_pcsrc = 1'b1; idex_dREN = 1'b1; idex_rt = 5'd4; ifid_rt = 5'd4;
    step("freeze_wins");
    dhit = 1'b1;
    step("redirect_after_dhit");
    quiet();

    // Redirect during an instruction fetch miss.
    exmem_pcsrc = 1'b1; ihit = 1'b0;
    step("redirect_imiss");
    quiet();

    // Halt drain sequence; inputs toggling while halted change nothing.
    exmem_halt = 1'b1;
    step("halt_mem");
    quiet();
    step("drain");
    for (int i = 0; i < 6; i++) begin
      ihit = i[0]; dhit = ~i[0]; exmem_dREN = 1'b1; exmem_pcsrc = i[1];
      step("halted");
    end
    quiet();
    RST = 1'b1;
    step("reset_halted");
    RST = 1'b0;
    step("after_reset");

    // Twenty fetch-miss stalls saturate the 4-bit counter at 15.
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) step("sat_stall");
    quiet();
    step("sat_hold");

    // Random traffic with occasional halts and resets.
    for (int i = 0; i < 3000; i++) begin
      RST         = ($urandom_range(0, 60) == 0);
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = ($urandom_range(0, 2) != 0);
      exmem_dREN  = ($urandom_range(0, 4) == 0);
      exmem_dWEN  = ($urandom_range(0, 5) == 0);
      exmem_pcsrc = ($urandom_range(0, 7) == 0);
      exmem_halt  = ($urandom_range(0, 40) == 0);
      idex_dREN   = ($urandom_range(0, 2) == 0);
      idex_rt     = 5'($urandom_range(0, 3));
      ifid_rs     = 5'($urandom_range(0, 3));
      ifid_rt     = 5'($urandom_range(0, 3));
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
